// File: rtl/pbit_sched_pkg.sv
// Shared types and defaults for the p-bit colour-sweep scheduler.
package pbit_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADV,
      SETTLE,
      UPD,
      SAMPLE,
      DONE
   } sched_state_t;

   localparam int DEF_NUM_COLORS    = 2;
   localparam int DEF_SETTLE_CYCLES = 1;
   localparam int DEF_SWEEP_W       = 32;

   // Width of the colour index; never narrower than one bit.
   function automatic int color_idx_w(input int num_colors);
      return (num_colors > 1) ? $clog2(num_colors) : 1;
   endfunction

endpackage

// File: rtl/pbit_color_scheduler.sv
// Graph-coloured sweep sequencer: advance LFSRs, settle, enable one colour
// group at a time, then strobe a sample; repeats for a bounded or free run.
module pbit_color_scheduler
   import pbit_sched_pkg::*;
#(
   parameter int NUM_COLORS    = DEF_NUM_COLORS,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SWEEP_W       = DEF_SWEEP_W
) (
   input  logic                  sample_clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  stop,
   input  logic [SWEEP_W-1:0]    num_sweeps,
   output logic                  rng_adv,
   output logic [NUM_COLORS-1:0] color_en,
   output logic                  sample_valid,
   output logic [SWEEP_W-1:0]    sweep_count,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = color_idx_w(NUM_COLORS);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0]      LAST_COLOR  = CW'(NUM_COLORS - 1);
   localparam logic [SW-1:0]      SETTLE_LAST = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;
   localparam logic [SWEEP_W-1:0] COUNT_MAX   = '1;

   sched_state_t       state;
   logic [CW-1:0]      c;
   logic [SW-1:0]      settle_cnt;
   logic [SWEEP_W-1:0] limit;
   logic               stop_pending;
   logic [SWEEP_W-1:0] next_count;

   // Free-running counts stick at all-ones instead of wrapping.
   assign next_count = (sweep_count == COUNT_MAX) ? sweep_count : sweep_count + SWEEP_W'(1);

   // Outputs are loaded together with the state they belong to, so every
   // strobe is a flop and lines up exactly with its state cycle.
   always_ff @(posedge sample_clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         c            <= '0;
         settle_cnt   <= '0;
         limit        <= '0;
         stop_pending <= 1'b0;
         rng_adv      <= 1'b0;
         color_en     <= '0;
         sample_valid <= 1'b0;
         sweep_count  <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         rng_adv      <= 1'b0;
         color_en     <= '0;
         sample_valid <= 1'b0;
         done         <= 1'b0;
         if (stop && (state != IDLE)) begin
            stop_pending <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  limit        <= num_sweeps;
                  sweep_count  <= '0;
                  c            <= '0;
                  stop_pending <= stop;
                  state        <= ADV;
                  rng_adv      <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            ADV: begin
               if (SETTLE_CYCLES == 0) begin
                  state    <= UPD;
                  color_en <= NUM_COLORS'(1) << c;
               end else begin
                  state      <= SETTLE;
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  state    <= UPD;
                  color_en <= NUM_COLORS'(1) << c;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            UPD: begin
               if (c == LAST_COLOR) begin
                  state        <= SAMPLE;
                  sample_valid <= 1'b1;
               end else begin
                  c       <= c + CW'(1);
                  state   <= ADV;
                  rng_adv <= 1'b1;
               end
            end
            SAMPLE: begin
               sweep_count <= next_count;
               c           <= '0;
               // A limit hit outranks a pending stop on the same boundary.
               if ((limit != '0) && (next_count == limit)) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else if (stop_pending || stop) begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  stop_pending <= 1'b0;
               end else begin
                  state   <= ADV;
                  rng_adv <= 1'b1;
               end
            end
            DONE: begin
               state        <= IDLE;
               busy         <= 1'b0;
               stop_pending <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pbit_color_scheduler.sv
// Scoreboard bench: three scheduler configurations driven with directed runs.
`timescale 1ns/1ps
module tb_pbit_color_scheduler;

   typedef struct {
      int         dut;
      int         cyc;
      logic [5:0] pulses;
      int         count;
   } evt_t;

   localparam logic [5:0] P_RNG    = 6'b000001;
   localparam logic [5:0] P_SAMPLE = 6'b010000;
   localparam logic [5:0] P_DONE   = 6'b100000;

   logic sample_clk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   evt_t expq[$];

   logic        rst_a, rst_bc;
   logic        start_a, stop_a, start_b, stop_b, start_c, stop_c;
   logic [31:0] nsw_a, nsw_b;
   logic [2:0]  nsw_c;

   logic        rng_adv_a, sample_valid_a, busy_a, done_a;
   logic [1:0]  color_en_a;
   logic [31:0] sweep_count_a;
   logic        rng_adv_b, sample_valid_b, busy_b, done_b;
   logic [2:0]  color_en_b;
   logic [31:0] sweep_count_b;
   logic        rng_adv_c, sample_valid_c, busy_c, done_c;
   logic [1:0]  color_en_c;
   logic [2:0]  sweep_count_c;

   logic [5:0]  pa, pb, pc;

   pbit_color_scheduler #(.NUM_COLORS(2), .SETTLE_CYCLES(1), .SWEEP_W(32)) dut_a (
      .sample_clk(sample_clk), .rst_n(rst_a), .start(start_a), .stop(stop_a),
      .num_sweeps(nsw_a), .rng_adv(rng_adv_a), .color_en(color_en_a),
      .sample_valid(sample_valid_a), .sweep_count(sweep_count_a), .busy(busy_a), .done(done_a));

   pbit_color_scheduler #(.NUM_COLORS(3), .SETTLE_CYCLES(0), .SWEEP_W(32)) dut_b (
      .sample_clk(sample_clk), .rst_n(rst_bc), .start(start_b), .stop(stop_b),
      .num_sweeps(nsw_b), .rng_adv(rng_adv_b), .color_en(color_en_b),
      .sample_valid(sample_valid_b), .sweep_count(sweep_count_b), .busy(busy_b), .done(done_b));

   pbit_color_scheduler #(.NUM_COLORS(2), .SETTLE_CYCLES(1), .SWEEP_W(3)) dut_c (
      .sample_clk(sample_clk), .rst_n(rst_bc), .start(start_c), .stop(stop_c),
      .num_sweeps(nsw_c), .rng_adv(rng_adv_c), .color_en(color_en_c),
      .sample_valid(sample_valid_c), .sweep_count(sweep_count_c), .busy(busy_c), .done(done_c));

   always #5 sample_clk = ~sample_clk;

   always @(posedge sample_clk) cyc <= cyc + 1;

   task automatic checkValue(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input int dut, input logic [5:0] pulses, input int count);
      evt_t e;
      checks++;
      if (expq.size() == 0) begin
         errors++;
         $display("[TB] FAIL unexpected_event: dut=%0d cyc=%0d pulses=%b count=%0d, expected no event",
                  dut, cyc, pulses, count);
         return;
      end
      e = expq.pop_front();
      if ((e.dut != dut) || (e.cyc != cyc) || (e.pulses != pulses) || (e.count != count)) begin
         errors++;
         $display("[TB] FAIL event: got dut=%0d cyc=%0d pulses=%b count=%0d, expected dut=%0d cyc=%0d pulses=%b count=%0d",
                  dut, cyc, pulses, count, e.dut, e.cyc, e.pulses, e.count);
      end
   endtask

   // Monitor: every output pulse must match the head of the scoreboard.
   always @(negedge sample_clk) begin
      pa = {done_a, sample_valid_a, 1'b0, color_en_a, rng_adv_a};
      pb = {done_b, sample_valid_b, color_en_b, rng_adv_b};
      pc = {done_c, sample_valid_c, 1'b0, color_en_c, rng_adv_c};
      if (pa != 6'b0) checkOutput(0, pa, int'(sweep_count_a));
      if (pb != 6'b0) checkOutput(1, pb, int'(sweep_count_b));
      if (pc != 6'b0) checkOutput(2, pc, int'(sweep_count_c));
      excl_a: assert ($countones({rng_adv_a, color_en_a, sample_valid_a}) <= 1)
         else begin errors++; $display("[TB] FAIL exclusivity_a at cyc %0d", cyc); end
      excl_b: assert ($countones({rng_adv_b, color_en_b, sample_valid_b}) <= 1)
         else begin errors++; $display("[TB] FAIL exclusivity_b at cyc %0d", cyc); end
      excl_c: assert ($countones({rng_adv_c, color_en_c, sample_valid_c}) <= 1)
         else begin errors++; $display("[TB] FAIL exclusivity_c at cyc %0d", cyc); end
   end

   function automatic void pushEvt(input int dut, input int at, input logic [5:0] p, input int cnt);
      evt_t e;
      e.dut = dut; e.cyc = at; e.pulses = p; e.count = cnt;
      expq.push_back(e);
   endfunction

   // n = -1: only the opening rng_adv is expected (run is cut by reset).
   function automatic void expectRun(input int dut, input int t0, input int n, input bit with_done);
      int nc, s, maxc, len, base, cnt;
      nc   = (dut == 1) ? 3 : 2;
      s    = (dut == 1) ? 0 : 1;
      maxc = (dut == 2) ? 7 : (1 << 30);
      len  = nc * (2 + s) + 1;
      if (n < 0) begin
         pushEvt(dut, t0, P_RNG, 0);
         return;
      end
      for (int sw = 0; sw < n; sw++) begin
         base = t0 + sw * len;
         cnt  = (sw > maxc) ? maxc : sw;
         for (int i = 0; i < nc; i++) begin
            pushEvt(dut, base + i * (2 + s), P_RNG, cnt);
            pushEvt(dut, base + i * (2 + s) + 1 + s, 6'(2 << i), cnt);
         end
         pushEvt(dut, base + nc * (2 + s), P_SAMPLE, cnt);
      end
      if (with_done) pushEvt(dut, t0 + n * len, P_DONE, (n > maxc) ? maxc : n);
   endfunction

   task automatic driveInputs(input int dut, input logic st, input logic sp, input int nsw);
      case (dut)
         0: begin start_a = st; stop_a = sp; nsw_a = nsw; end
         1: begin start_b = st; stop_b = sp; nsw_b = nsw; end
         default: begin start_c = st; stop_c = sp; nsw_c = 3'(nsw); end
      endcase
   endtask

   // One-cycle start/stop pulse; t0 is the cycle the first rng_adv should show.
   task automatic applyStimulus(input int dut, input logic st, input logic sp, input int nsw,
                                input int n_exp, input bit with_done, output int t0);
      @(negedge sample_clk);
      t0 = cyc + 1;
      if (n_exp != 0) expectRun(dut, t0, n_exp, with_done);
      driveInputs(dut, st, sp, nsw);
      @(negedge sample_clk);
      driveInputs(dut, 1'b0, 1'b0, nsw);
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) @(negedge sample_clk);
   endtask

   task automatic pulseStop(input int dut);
      case (dut)
         0: stop_a = 1'b1;
         1: stop_b = 1'b1;
         default: stop_c = 1'b1;
      endcase
      @(negedge sample_clk);
      stop_a = 1'b0; stop_b = 1'b0; stop_c = 1'b0;
   endtask

   task automatic waitIdle(input int dut, input int budget, output int t_idle);
      logic b;
      t_idle = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge sample_clk);
         b = (dut == 0) ? busy_a : (dut == 1) ? busy_b : busy_c;
         if (!b) begin
            t_idle = cyc;
            return;
         end
      end
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: dut=%0d still busy after %0d cycles, expected idle", dut, budget);
   endtask

   initial begin
      int t0, tx, ti;
      rst_a = 1'b0; rst_bc = 1'b0;
      driveInputs(0, 1'b0, 1'b0, 0);
      driveInputs(1, 1'b0, 1'b0, 0);
      driveInputs(2, 1'b0, 1'b0, 0);
      repeat (3) @(negedge sample_clk);
      checkValue("reset_rng_adv", rng_adv_a, 0);
      checkValue("reset_color_en", color_en_a, 0);
      checkValue("reset_sample_valid", sample_valid_a, 0);
      checkValue("reset_sweep_count", sweep_count_a, 0);
      checkValue("reset_busy", busy_a, 0);
      checkValue("reset_done", done_a, 0);
      checkValue("reset_busy_b", busy_b, 0);
      checkValue("reset_busy_c", busy_c, 0);
      rst_a = 1'b1; rst_bc = 1'b1;

      $display("[TB] bounded run of 3 sweeps with a dropped mid-run start");
      applyStimulus(0, 1'b1, 1'b0, 3, 3, 1'b1, t0);
      waitUntil(t0 + 9);
      applyStimulus(0, 1'b1, 1'b0, 1, 0, 1'b0, tx);
      waitIdle(0, 60, ti);
      checkValue("bounded_busy_fall", ti, t0 + 22);
      checkValue("bounded_sweep_count", sweep_count_a, 3);

      $display("[TB] free run stopped during colour 0 of sweep 5");
      applyStimulus(0, 1'b1, 1'b0, 0, 5, 1'b0, t0);
      waitUntil(t0 + 4 * 7 + 2);
      pulseStop(0);
      waitIdle(0, 60, ti);
      checkValue("stop_busy_fall", ti, t0 + 35);
      checkValue("stop_sweep_count", sweep_count_a, 5);

      $display("[TB] start and stop together");
      applyStimulus(0, 1'b1, 1'b1, 0, 1, 1'b0, t0);
      waitIdle(0, 30, ti);
      checkValue("start_stop_busy_fall", ti, t0 + 7);
      checkValue("start_stop_sweep_count", sweep_count_a, 1);

      $display("[TB] reset during settle, then clean restart");
      applyStimulus(0, 1'b1, 1'b0, 2, -1, 1'b0, t0);
      @(negedge sample_clk);
      rst_a = 1'b0;
      @(negedge sample_clk);
      checkValue("midreset_rng_adv", rng_adv_a, 0);
      checkValue("midreset_color_en", color_en_a, 0);
      checkValue("midreset_busy", busy_a, 0);
      checkValue("midreset_sweep_count", sweep_count_a, 0);
      rst_a = 1'b1;
      repeat (20) @(negedge sample_clk);
      applyStimulus(0, 1'b1, 1'b0, 1, 1, 1'b1, t0);
      waitIdle(0, 30, ti);
      checkValue("restart_busy_fall", ti, t0 + 8);
      checkValue("restart_sweep_count", sweep_count_a, 1);

      $display("[TB] three colours, no settle, single sweep");
      applyStimulus(1, 1'b1, 1'b0, 1, 1, 1'b1, t0);
      waitIdle(1, 30, ti);
      checkValue("nc3_busy_fall", ti, t0 + 8);
      checkValue("nc3_sweep_count", sweep_count_b, 1);

      $display("[TB] 3-bit counter saturation over 10 sweeps");
      applyStimulus(2, 1'b1, 1'b0, 0, 10, 1'b0, t0);
      waitUntil(t0 + 9 * 7 + 2);
      pulseStop(2);
      waitIdle(2, 60, ti);
      checkValue("sat_busy_fall", ti, t0 + 70);
      checkValue("sat_sweep_count", sweep_count_c, 7);

      repeat (3) @(negedge sample_clk);
      checkValue("scoreboard_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/pbit_color_scheduler.md
# pbit_color_scheduler

Sequencing controller for the sparse p-bit Ising array. It replaces the phase-shifted PLL clocks that currently order p-bit updates: on a single clock it runs graph-coloured sweeps. Each sweep advances the LFSRs, waits for the RNG bits to settle, then pulses one colour-group enable at a time, and closes with a sample strobe. Colour groups update strictly one at a time, so p-bits of the same colour never read a neighbour mid-update.

## Interface
Parameters:
- NUM_COLORS, default 2: number of colour groups, at least 2.
- SETTLE_CYCLES, default 1: wait cycles between `rng_adv` and `color_en`; 0 is legal and skips the wait.
- SWEEP_W, default 32: width of the sweep counter and sweep limit.

Ports:
- sample_clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a run; ignored while `busy`.
- stop  in  1  single-cycle request to end the run at the next sweep boundary.
- num_sweeps  in  SWEEP_W  sweep limit, latched on start; 0 means free-run.
- rng_adv  out  1  one-cycle pulse to advance all LFSRs.
- color_en  out  NUM_COLORS  one-hot, one-cycle update enable for colour group c.
- sample_valid  out  1  one-cycle strobe after the last colour of each sweep.
- sweep_count  out  SWEEP_W  completed sweeps in the current run.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a bounded run completes.

## Operation
- States: IDLE, ADV, SETTLE, UPD, SAMPLE, DONE. Colour index `c` runs from 0 to NUM_COLORS-1.
- IDLE:
  - On `start`: latch `num_sweeps`, clear `sweep_count` and `c`, clear `stop_pending`, go to ADV.
  - `stop` is ignored in IDLE, except when it arrives in the same cycle as `start`.
- ADV: `rng_adv`=1. Go to SETTLE, or straight to UPD if SETTLE_CYCLES=0.
- SETTLE: hold for exactly SETTLE_CYCLES cycles, then go to UPD.
- UPD: `color_en[c]`=1.
  - If `c` < NUM_COLORS-1: increment `c`, go to ADV.
  - Otherwise: go to SAMPLE.
- SAMPLE: `sample_valid`=1 and `sweep_count` increments. `sample_valid` is asserted in the same cycle as the increment; the new count is visible the following cycle. Then:
  - If limit ≠ 0 and the new count equals the limit: go to DONE.
  - Else if `stop_pending`: go to IDLE.
  - Else: `c`=0, go to ADV.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Stop handling:
  - `stop_pending` is set by `stop` while `busy`, or by `stop` in the same cycle as an accepted `start`.
  - Sweeps are never truncated: a run that has started always finishes its current sweep, including SAMPLE.
  - If a stop and the limit land on the same sweep boundary, DONE takes priority.
- Output exclusivity: at most one of `rng_adv`, `color_en` (any bit) and `sample_valid` is high in any cycle.
- `sweep_count` saturates at all-ones in free-run and does not wrap.
- `sweep_count` holds its last value in IDLE until the next accepted `start`.

## Timing
- Reset values: all outputs 0, state IDLE, `c`=0, `stop_pending`=0.
- Reset asserted mid-sweep forces IDLE at the next edge. No further `color_en` or `sample_valid` is issued and no `done` pulse is produced.
- `start` is accepted at edge k. `rng_adv` is high during cycle k+1. `color_en[0]` is high during cycle k+2+SETTLE_CYCLES.
- Sweep length: NUM_COLORS×(2+SETTLE_CYCLES)+1 cycles. With defaults this is 7.
- Bounded run of N sweeps: `done` is high one cycle after the final `sample_valid`. `busy` falls the cycle after `done`.
- `start` while `busy` is dropped and not queued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `pbit_sched_pkg` holds:
  - the state enum (`sched_state_t`);
  - default values for NUM_COLORS, SETTLE_CYCLES and SWEEP_W;
  - a `clog2`-based colour index width.
- One module only. The settle counter, colour index and sweep counter are inline counters; no sub-module is needed.
- The LFSR and p-bit logic are unchanged apart from gating:
  - the LFSRs advance on `rng_adv`;
  - the p-bit update for group c fires on `color_en[c]`.

## Test plan
- Reset, then `start` with `num_sweeps`=3 and defaults:
  - per sweep, `rng_adv`, `color_en`=01, `rng_adv`, `color_en`=10, `sample_valid`, with a 7-cycle period;
  - `sweep_count` reads 1, 2, 3;
  - `done` one cycle after the 3rd strobe;
  - `busy` low one cycle after `done`.
- SETTLE_CYCLES=0, NUM_COLORS=3, `num_sweeps`=1: sweep is 7 cycles, `color_en` goes 001, 010, 100, then `done`.
- Free-run (`num_sweeps`=0) with `stop` pulsed during `color_en[0]` of sweep 5:
  - `color_en[1]` and `sample_valid` still occur;
  - `sweep_count`=5, returns to IDLE, no `done`.
- `start` pulsed again while `busy`: no effect on sequence or counts. `start` and `stop` in the same cycle from IDLE: exactly one sweep, then IDLE.
- Reset asserted during SETTLE:
  - all outputs 0 at the next edge;
  - no `color_en` or `sample_valid` afterwards;
  - a new `start` gives a clean restart with `sweep_count` back at 0.
- Small counter (SWEEP_W=3), free-run for 10 sweeps: `sweep_count` saturates at 7 while `sample_valid` continues every sweep. Output exclusivity is checked by assertion throughout all tests.
